// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: boots the fetch unit, redirects it on resolved branches,
// flushes wrong-path fetches, freezes it on hazards and drains the pipe on halt.
module fetch_sequencer #(
  parameter int                 PC_W         = 16,
  parameter int                 INSTR_W      = 9,
  parameter logic [INSTR_W-1:0] HALT_OPCODE  = 9'h1FF,
  parameter int                 BOOT_CYCLES  = 2,
  parameter int                 FLUSH_CYCLES = 2,
  parameter int                 DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_req,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               stall_req,
  input  logic               branch_resolve,
  input  logic               branch_taken,
  input  logic               branch_dir,
  input  logic [PC_W-1:0]    branch_offset,
  output logic               fetch_init,
  output logic               fetch_start,
  output logic               fetch_branch,
  output logic               fetch_taken,
  output logic               fetch_jump_sign,
  output logic [PC_W-1:0]    fetch_target,
  output logic               pc_hold,
  output logic               flush,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        cycle_count,
  output logic [15:0]        instr_count
);

  typedef enum logic [2:0] {IDLE, BOOT, RUN, STALL, FLUSH, DRAIN, HALTED} state_t;

  localparam logic [7:0] BOOT_LAST  = 8'(BOOT_CYCLES - 1);
  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [7:0] phase_cnt;
  logic       halt_hit;

  assign halt_hit = (instr_in == HALT_OPCODE);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      phase_cnt       <= 8'd0;
      fetch_init      <= 1'b0;
      fetch_start     <= 1'b0;
      fetch_branch    <= 1'b0;
      fetch_taken     <= 1'b0;
      fetch_jump_sign <= 1'b0;
      fetch_target    <= '0;
      pc_hold         <= 1'b0;
      flush           <= 1'b0;
      busy            <= 1'b0;
      halted          <= 1'b0;
      cycle_count     <= 16'd0;
      instr_count     <= 16'd0;
    end else begin
      fetch_branch <= 1'b0;
      fetch_start  <= 1'b0;

      if (state inside {BOOT, RUN, STALL, FLUSH, DRAIN})
        cycle_count <= sat_inc(cycle_count);
      if (state == RUN && !pc_hold && !flush)
        instr_count <= sat_inc(instr_count);

      case (state)
        IDLE, HALTED: begin
          if (run_req) begin
            state       <= BOOT;
            phase_cnt   <= 8'd0;
            fetch_init  <= 1'b1;
            pc_hold     <= 1'b0;
            halted      <= 1'b0;
            busy        <= 1'b1;
            cycle_count <= 16'd0;
            instr_count <= 16'd0;
          end
        end

        BOOT: begin
          if (phase_cnt == BOOT_LAST) begin
            state      <= RUN;
            fetch_init <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        // A resolved branch outranks halt and stall; a stall raised alongside
        // a taken branch is dropped and must be reasserted by decode.
        RUN, STALL: begin
          if (branch_resolve) begin
            fetch_branch    <= 1'b1;
            fetch_taken     <= branch_taken;
            fetch_jump_sign <= branch_dir;
            fetch_target    <= branch_offset;
            pc_hold         <= 1'b0;
            if (branch_taken) begin
              state     <= FLUSH;
              flush     <= 1'b1;
              phase_cnt <= 8'd0;
            end else begin
              state <= RUN;
            end
          end else if (halt_hit) begin
            state     <= DRAIN;
            pc_hold   <= 1'b1;
            phase_cnt <= 8'd0;
          end else if (stall_req) begin
            state   <= STALL;
            pc_hold <= 1'b1;
          end else begin
            state   <= RUN;
            pc_hold <= 1'b0;
          end
        end

        // The fetched word is wrong-path here, so halt and stall are ignored.
        FLUSH: begin
          if (branch_resolve) begin
            fetch_branch    <= 1'b1;
            fetch_taken     <= branch_taken;
            fetch_jump_sign <= branch_dir;
            fetch_target    <= branch_offset;
            phase_cnt       <= 8'd0;
          end else if (phase_cnt == FLUSH_LAST) begin
            state <= RUN;
            flush <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        DRAIN: begin
          if (phase_cnt == DRAIN_LAST) begin
            state       <= HALTED;
            halted      <= 1'b1;
            fetch_start <= 1'b1;
            busy        <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle-by-cycle vector table through a scoreboard
// queue, then reset-in-FLUSH, reboot and counter saturation sequences.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, run_req, stall_req, branch_resolve, branch_taken, branch_dir;
  logic [8:0]  instr_in;
  logic [15:0] branch_offset;
  logic        fetch_init, fetch_start, fetch_branch, fetch_taken, fetch_jump_sign;
  logic [15:0] fetch_target;
  logic        pc_hold, flush, busy, halted;
  logic [15:0] cycle_count, instr_count;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .run_req(run_req), .instr_in(instr_in),
    .stall_req(stall_req), .branch_resolve(branch_resolve),
    .branch_taken(branch_taken), .branch_dir(branch_dir),
    .branch_offset(branch_offset), .fetch_init(fetch_init),
    .fetch_start(fetch_start), .fetch_branch(fetch_branch),
    .fetch_taken(fetch_taken), .fetch_jump_sign(fetch_jump_sign),
    .fetch_target(fetch_target), .pc_hold(pc_hold), .flush(flush),
    .busy(busy), .halted(halted), .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // in_bits = {run_req, stall_req, branch_resolve, branch_taken, branch_dir}
  // exp_ctl = {init, start, branch, taken, jump_sign, pc_hold, flush, busy, halted}
  typedef struct {
    logic [4:0]  in_bits;
    logic [8:0]  instr;
    logic [15:0] off;
    logic [8:0]  exp_ctl;
    logic [15:0] exp_tgt;
    logic [15:0] exp_ic;
    logic [15:0] exp_cc;
  } vec_t;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[30];
  vec_t exp_q[$];
  int   init_cycles;

  function automatic vec_t mk(input logic [4:0] ib, input logic [8:0] ins,
                              input logic [15:0] off, input logic [8:0] ctl,
                              input logic [15:0] tgt, input logic [15:0] ic,
                              input logic [15:0] cc);
    vec_t v;
    v.in_bits = ib; v.instr = ins; v.off = off; v.exp_ctl = ctl;
    v.exp_tgt = tgt; v.exp_ic = ic; v.exp_cc = cc;
    return v;
  endfunction

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    run_req = 1'b0; stall_req = 1'b0; branch_resolve = 1'b0;
    branch_taken = 1'b0; branch_dir = 1'b0; instr_in = 9'h000; branch_offset = 16'h0;
  endtask

  task automatic check_zero(input string tag);
    check16({tag, "_init"},   16'(fetch_init), 16'h0);
    check16({tag, "_start"},  16'(fetch_start), 16'h0);
    check16({tag, "_branch"}, 16'(fetch_branch), 16'h0);
    check16({tag, "_taken"},  16'(fetch_taken), 16'h0);
    check16({tag, "_sign"},   16'(fetch_jump_sign), 16'h0);
    check16({tag, "_target"}, fetch_target, 16'h0);
    check16({tag, "_hold"},   16'(pc_hold), 16'h0);
    check16({tag, "_flush"},  16'(flush), 16'h0);
    check16({tag, "_busy"},   16'(busy), 16'h0);
    check16({tag, "_halted"}, 16'(halted), 16'h0);
    check16({tag, "_cc"},     cycle_count, 16'h0);
    check16({tag, "_ic"},     instr_count, 16'h0);
  endtask

  task automatic compare_row(input int idx, input vec_t e);
    string t;
    t = $sformatf("row%0d", idx);
    check16({t, "_init"},   16'(fetch_init),   16'(e.exp_ctl[8]));
    check16({t, "_start"},  16'(fetch_start),  16'(e.exp_ctl[7]));
    check16({t, "_branch"}, 16'(fetch_branch), 16'(e.exp_ctl[6]));
    if (e.exp_ctl[6]) begin
      check16({t, "_taken"},  16'(fetch_taken),     16'(e.exp_ctl[5]));
      check16({t, "_sign"},   16'(fetch_jump_sign), 16'(e.exp_ctl[4]));
      check16({t, "_target"}, fetch_target,         e.exp_tgt);
    end
    check16({t, "_hold"},   16'(pc_hold), 16'(e.exp_ctl[3]));
    check16({t, "_flush"},  16'(flush),   16'(e.exp_ctl[2]));
    check16({t, "_busy"},   16'(busy),    16'(e.exp_ctl[1]));
    check16({t, "_halted"}, 16'(halted),  16'(e.exp_ctl[0]));
    check16({t, "_ic"},     instr_count,  e.exp_ic);
    check16({t, "_cc"},     cycle_count,  e.exp_cc);
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    run_req        = v.in_bits[4];
    stall_req      = v.in_bits[3];
    branch_resolve = v.in_bits[2];
    branch_taken   = v.in_bits[1];
    branch_dir     = v.in_bits[0];
    instr_in       = v.instr;
    branch_offset  = v.off;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    compare_row(idx, exp_q.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    vecs[0]  = mk(5'b00000, 9'h000, 16'h0000, 9'b000000000, 16'h0000, 16'd0,  16'd0);
    vecs[1]  = mk(5'b10000, 9'h000, 16'h0000, 9'b100000010, 16'h0000, 16'd0,  16'd0);
    vecs[2]  = mk(5'b00000, 9'h000, 16'h0000, 9'b100000010, 16'h0000, 16'd0,  16'd1);
    vecs[3]  = mk(5'b00000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd0,  16'd2);
    vecs[4]  = mk(5'b00000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd1,  16'd3);
    vecs[5]  = mk(5'b10000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd2,  16'd4);
    vecs[6]  = mk(5'b00110, 9'h000, 16'h0004, 9'b001100110, 16'h0004, 16'd3,  16'd5);
    vecs[7]  = mk(5'b01000, 9'h1FF, 16'h0000, 9'b000000110, 16'h0000, 16'd3,  16'd6);
    vecs[8]  = mk(5'b00000, 9'h1FF, 16'h0000, 9'b000000010, 16'h0000, 16'd3,  16'd7);
    vecs[9]  = mk(5'b00000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd4,  16'd8);
    vecs[10] = mk(5'b00101, 9'h000, 16'h0010, 9'b001010010, 16'h0010, 16'd5,  16'd9);
    vecs[11] = mk(5'b00000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd6,  16'd10);
    vecs[12] = mk(5'b01111, 9'h000, 16'h0008, 9'b001110110, 16'h0008, 16'd7,  16'd11);
    vecs[13] = mk(5'b01000, 9'h000, 16'h0000, 9'b000000110, 16'h0000, 16'd7,  16'd12);
    vecs[14] = mk(5'b01000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd7,  16'd13);
    vecs[15] = mk(5'b00000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd8,  16'd14);
    vecs[16] = mk(5'b01000, 9'h000, 16'h0000, 9'b000001010, 16'h0000, 16'd9,  16'd15);
    vecs[17] = mk(5'b01000, 9'h000, 16'h0000, 9'b000001010, 16'h0000, 16'd9,  16'd16);
    vecs[18] = mk(5'b01000, 9'h000, 16'h0000, 9'b000001010, 16'h0000, 16'd9,  16'd17);
    vecs[19] = mk(5'b00000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd9,  16'd18);
    vecs[20] = mk(5'b00000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd10, 16'd19);
    vecs[21] = mk(5'b00000, 9'h1FF, 16'h0000, 9'b000001010, 16'h0000, 16'd11, 16'd20);
    vecs[22] = mk(5'b00111, 9'h000, 16'h0005, 9'b000001010, 16'h0000, 16'd11, 16'd21);
    vecs[23] = mk(5'b00000, 9'h000, 16'h0000, 9'b000001010, 16'h0000, 16'd11, 16'd22);
    vecs[24] = mk(5'b00000, 9'h000, 16'h0000, 9'b010001001, 16'h0000, 16'd11, 16'd23);
    vecs[25] = mk(5'b00000, 9'h000, 16'h0000, 9'b000001001, 16'h0000, 16'd11, 16'd23);
    vecs[26] = mk(5'b10000, 9'h000, 16'h0000, 9'b100000010, 16'h0000, 16'd0,  16'd0);
    vecs[27] = mk(5'b00000, 9'h000, 16'h0000, 9'b100000010, 16'h0000, 16'd0,  16'd1);
    vecs[28] = mk(5'b00000, 9'h000, 16'h0000, 9'b000000010, 16'h0000, 16'd0,  16'd2);
    vecs[29] = mk(5'b00111, 9'h000, 16'h0002, 9'b001110110, 16'h0002, 16'd1,  16'd3);

    for (int i = 0; i < 30; i++) apply(i, vecs[i]);

    // Reset lands while flush is still high from the last branch.
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_zero("midflush_reset");

    @(negedge clk);
    reset   = 1'b0;
    run_req = 1'b1;
    init_cycles = 0;
    @(posedge clk);
    #1;
    if (fetch_init) init_cycles++;
    @(negedge clk);
    run_req = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (fetch_init) init_cycles++;
    end
    check16("reboot_init_cycles", 16'(init_cycles), 16'd2);

    // Long run with no halt: both counters must pin at full scale.
    repeat (70000) @(posedge clk);
    #1;
    check16("sat_cycle_count", cycle_count, 16'hFFFF);
    check16("sat_instr_count", instr_count, 16'hFFFF);
    check16("sat_busy",        16'(busy),   16'h1);
    check16("sat_halted",      16'(halted), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
